int_sync_crossing_source_n: RTL and testbench

INT_SYNC_CROSSING_SOURCE_N -- requirements
Module: int_sync_crossing_source_n

---
 rtl/int_sync_crossing_source_n.sv | 82 ++++++++
 tb/tb_int_sync_crossing_source_n.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/int_sync_crossing_source_n.sv
// int_sync_crossing_source_n: source side of an interrupt crossing; level channels are registered copies, edge channels run a 4-phase req/ack handshake
module int_sync_crossing_source_n #(
   parameter int               WIDTH      = 1,
   parameter logic [WIDTH-1:0] EDGE_MASK  = '0,
   parameter int               ACK_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] auto_in,
   output logic [WIDTH-1:0] auto_out_sync,
   input  logic [WIDTH-1:0] auto_out_ack,
   output logic [WIDTH-1:0] overflow,
   input  logic [WIDTH-1:0] overflow_clr
);
   // Bit 0 of the encoding is the request line, so the output is a bare flop.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] REQ  = 2'b01;
   localparam logic [1:0] DROP = 2'b10;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      if (EDGE_MASK[i]) begin : g_edge
         logic [1:0]            state_q, state_d;
         logic                  prev_q, queued_q, queued_d, ovf_q, ovf_d, edge_w, ack_s;
         logic [ACK_STAGES-1:0] ack_q;

         assign edge_w = auto_in[i] & ~prev_q;
         assign ack_s  = ack_q[ACK_STAGES-1];

         // State, pending-edge, overflow, input history and ack synchronizer registers
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               state_q  <= IDLE;
               queued_q <= 1'b0;
               ovf_q    <= 1'b0;
               prev_q   <= 1'b0;
               ack_q    <= '0;
            end else begin
               state_q  <= state_d;
               queued_q <= queued_d;
               ovf_q    <= ovf_d;
               prev_q   <= auto_in[i];
               ack_q    <= {ack_q[ACK_STAGES-2:0], auto_out_ack[i]};
            end
         end

         // Handshake progression; edges arriving mid-handshake are queued once, further ones flag overflow
         always_comb begin
            state_d  = state_q;
            queued_d = queued_q;
            ovf_d    = ovf_q & ~overflow_clr[i];
            if (state_q == IDLE) begin
               state_d = edge_w ? REQ : IDLE;
            end else if (state_q == DROP && !ack_s) begin
               state_d  = (edge_w || queued_q) ? REQ : IDLE;
               queued_d = queued_q & edge_w;
            end else if (state_q == REQ || state_q == DROP) begin
               state_d  = (state_q == REQ && ack_s) ? DROP : state_q;
               queued_d = queued_q | edge_w;
               ovf_d    = ovf_d | (queued_q & edge_w);
            end else begin
               state_d = IDLE;
            end
         end

         assign auto_out_sync[i] = state_q[0];
         assign overflow[i]      = ovf_q;
      end else begin : g_level
         logic lvl_q;
         logic unused_lvl;

         // One-cycle registered copy of the level interrupt
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) lvl_q <= 1'b0;
            else          lvl_q <= auto_in[i];
         end

         assign auto_out_sync[i] = lvl_q;
         assign overflow[i]      = 1'b0;
         assign unused_lvl       = auto_out_ack[i] ^ overflow_clr[i];
      end
   end
endmodule

// File: tb/tb_int_sync_crossing_source_n.sv
// tb_int_sync_crossing_source_n: directed checks of a mixed level/edge crossing source
module tb_int_sync_crossing_source_n;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] auto_in = '0;
   logic [7:0] auto_out_ack = '0;
   logic [7:0] overflow_clr = '0;
   logic [7:0] auto_out_sync, overflow;
   logic [3:0] v;
   int         total = 0;
   int         bad = 0;

   always #5 clock = ~clock;

   int_sync_crossing_source_n #(.WIDTH(8), .EDGE_MASK(8'hF0), .ACK_STAGES(2)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .auto_in       (auto_in),
      .auto_out_sync (auto_out_sync),
      .auto_out_ack  (auto_out_ack),
      .overflow      (overflow),
      .overflow_clr  (overflow_clr)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      step(3);
      chk("reset_sync", auto_out_sync, 8'h00);
      chk("reset_ovf", overflow, 8'h00);
      reset_n = 1'b1;
      step(1);
      chk("post_reset_quiet", auto_out_sync, 8'h00);
      // level channels: one-cycle copy
      auto_in = 8'h0A; step(1);
      chk("lvl_1010", auto_out_sync, 8'h0A);
      auto_in = 8'h05; #2;
      chk("lvl_hold", auto_out_sync, 8'h0A);
      step(1);
      chk("lvl_0101", auto_out_sync, 8'h05);
      // edge channel 4: basic handshake
      auto_in = 8'h10; step(1);
      chk("edge_req", auto_out_sync, 8'h10);
      auto_in = 8'h00; auto_out_ack = 8'h10; step(2);
      chk("edge_ack_sync_wait", auto_out_sync, 8'h10);
      step(1);
      chk("edge_drop", auto_out_sync, 8'h00);
      auto_out_ack = 8'h00; step(3);
      chk("edge_idle", auto_out_sync, 8'h00);
      auto_in = 8'h10; step(1);
      chk("edge_req2", auto_out_sync, 8'h10);
      // channel 4: three edges during handshake -> one queued, overflow
      auto_in = 8'h00; auto_out_ack = 8'h10; step(1);
      auto_in = 8'h10; step(1);
      chk("q_still_req", auto_out_sync, 8'h10);
      auto_in = 8'h00; step(1);
      chk("q_drop", auto_out_sync, 8'h00);
      chk("q_no_ovf", overflow, 8'h00);
      auto_in = 8'h10; step(1);
      chk("ovf_set", overflow, 8'h10);
      auto_in = 8'h00; step(1);
      auto_in = 8'h10; step(1);
      chk("ovf_sticky", overflow, 8'h10);
      chk("ovf_drop_out", auto_out_sync, 8'h00);
      auto_in = 8'h00; auto_out_ack = 8'h00; step(2);
      chk("requeue_wait", auto_out_sync, 8'h00);
      step(1);
      chk("requeue_req", auto_out_sync, 8'h10);
      overflow_clr = 8'h10; step(1);
      chk("ovf_clr", overflow, 8'h00);
      overflow_clr = 8'h00;
      auto_out_ack = 8'h10; step(3);
      chk("q_drained_drop", auto_out_sync, 8'h00);
      auto_out_ack = 8'h00; step(3);
      chk("q_drained_idle", auto_out_sync, 8'h00);
      step(1);
      chk("q_drained_idle2", auto_out_sync, 8'h00);
      // channel 5: edge coincident with synchronized ack low in DROP
      auto_in = 8'h20; step(1);
      chk("c_req", auto_out_sync, 8'h20);
      auto_in = 8'h00; auto_out_ack = 8'h20; step(3);
      chk("c_drop", auto_out_sync, 8'h00);
      auto_out_ack = 8'h00; step(2);
      auto_in = 8'h20; step(1);
      chk("coinc_req", auto_out_sync, 8'h20);
      chk("coinc_no_ovf", overflow, 8'h00);
      auto_in = 8'h00; auto_out_ack = 8'h20; step(3);
      chk("coinc_drop", auto_out_sync, 8'h00);
      auto_out_ack = 8'h00; step(3);
      chk("coinc_idle", auto_out_sync, 8'h00);
      // channel 5: overflow set beats clear
      auto_in = 8'h20; step(1);
      auto_in = 8'h00; step(1);
      auto_in = 8'h20; step(1);
      auto_in = 8'h00; step(1);
      chk("rq_no_ovf", overflow, 8'h00);
      auto_in = 8'h20; overflow_clr = 8'h20; step(1);
      chk("set_wins", overflow, 8'h20);
      auto_in = 8'h00; step(1);
      chk("clr_after", overflow, 8'h00);
      overflow_clr = 8'h00;
      // channel 5: coincident edge with queued set keeps queued, no overflow
      auto_out_ack = 8'h20; step(3);
      chk("q2_drop", auto_out_sync, 8'h00);
      auto_out_ack = 8'h00; step(2);
      auto_in = 8'h20; step(1);
      chk("q2_coinc_req", auto_out_sync, 8'h20);
      chk("q2_no_ovf", overflow, 8'h00);
      auto_in = 8'h00; auto_out_ack = 8'h20; step(3);
      chk("q2_drop2", auto_out_sync, 8'h00);
      auto_out_ack = 8'h00; step(3);
      chk("q2_stored_req", auto_out_sync, 8'h20);
      chk("q2_no_ovf2", overflow, 8'h00);
      auto_out_ack = 8'h20; step(3);
      auto_out_ack = 8'h00; step(3);
      chk("q2_final_idle", auto_out_sync, 8'h00);
      // level channels under random input; ack and clear must be ignored
      for (int k = 0; k < 200; k++) begin
         v = 4'($urandom);
         auto_in = {4'h0, v};
         auto_out_ack = {4'h0, 4'($urandom)};
         overflow_clr = {4'h0, 4'($urandom)};
         step(1);
         chk("lvl_rand", auto_out_sync, {4'h0, v});
         chk("lvl_rand_ovf", overflow, 8'h00);
      end
      auto_out_ack = 8'h00; overflow_clr = 8'h00;
      // asynchronous reset while channel 4 is in REQ with queued set and overflow
      auto_in = 8'h1F; step(1);
      auto_in = 8'h0F; step(1);
      auto_in = 8'h1F; step(1);
      auto_in = 8'h0F; step(1);
      auto_in = 8'h1F; step(1);
      chk("pre_rst_sync", auto_out_sync, 8'h1F);
      chk("pre_rst_ovf", overflow, 8'h10);
      #3 reset_n = 1'b0;
      #1;
      chk("async_rst_sync", auto_out_sync, 8'h00);
      chk("async_rst_ovf", overflow, 8'h00);
      auto_in = 8'h0F; step(2);
      reset_n = 1'b1;
      step(1);
      chk("post_rst_lvl", auto_out_sync, 8'h0F);
      step(3);
      chk("post_rst_no_req", auto_out_sync, 8'h0F);
      auto_in = 8'h1F; step(1);
      chk("post_rst_new_edge", auto_out_sync, 8'h1F);
      // input held high across reset counts as an edge on the first cycle
      auto_in = 8'h20; reset_n = 1'b0; step(2);
      chk("held_rst_sync", auto_out_sync, 8'h00);
      reset_n = 1'b1; step(1);
      chk("held_high_edge", auto_out_sync, 8'h20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
